// File: rtl/pc_next_unit_if.sv
// ---------------------------------------------------------------------------
// pc_next_unit_if
// Purpose : bundles the fetch handshake, the branch-control inputs and the
//           status outputs of the LEGv8 PC / next-PC stage.
// Modports:
//   master - the PC unit: drives fetch_valid, pc, pc_plus4, misalign_err,
//            fetch_count; samples fetch_ready, the branch controls and halt.
//   slave  - fetch/decode side: the mirror image of master.
// Signals :
//   fetch_valid / fetch_ready  fetch handshake (accept = valid & ready)
//   pc, pc_plus4               current fetch address and its successor
//   uncond_br, cond_br,
//   cond_true, br_reg          branch selection controls
//   imm26, imm19               signed word offsets for B/BL and CBZ/B.cond
//   reg_target                 BR target register value
//   halt                       halt request
//   misalign_err               one-cycle pulse on a misaligned BR target
//   fetch_count                number of accepted fetches
// ---------------------------------------------------------------------------
interface pc_next_unit_if #(
    parameter int unsigned CNT_W = 32
);
    logic             fetch_valid;
    logic             fetch_ready;
    logic [63:0]      pc;
    logic [63:0]      pc_plus4;
    logic             uncond_br;
    logic             cond_br;
    logic             cond_true;
    logic             br_reg;
    logic [25:0]      imm26;
    logic [18:0]      imm19;
    logic [63:0]      reg_target;
    logic             halt;
    logic             misalign_err;
    logic [CNT_W-1:0] fetch_count;

    modport master (
        output fetch_valid,
        output pc,
        output pc_plus4,
        output misalign_err,
        output fetch_count,
        input  fetch_ready,
        input  uncond_br,
        input  cond_br,
        input  cond_true,
        input  br_reg,
        input  imm26,
        input  imm19,
        input  reg_target,
        input  halt
    );

    modport slave (
        input  fetch_valid,
        input  pc,
        input  pc_plus4,
        input  misalign_err,
        input  fetch_count,
        output fetch_ready,
        output uncond_br,
        output cond_br,
        output cond_true,
        output br_reg,
        output imm26,
        output imm19,
        output reg_target,
        output halt
    );
endinterface

// File: rtl/pc_next_unit.sv
// ---------------------------------------------------------------------------
// pc_next_unit
// Purpose : 64-bit program counter and next-PC selection for the LEGv8
//           datapath. Presents pc / pc_plus4 to instruction fetch, advances
//           only when imem accepts the address, and selects the next PC from
//           BR > B/BL > taken CBZ/B.cond > sequential. A halt request moves
//           the unit into a terminal HALTED state that only reset leaves.
// Parameters:
//   RESET_PC  PC loaded on reset (low two bits forced to zero)
//   INSTR_B   bytes per instruction (sequential increment)
//   CNT_W     width of the accepted-fetch counter
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      pc_next_unit_if.master (fetch handshake, branch controls,
//            pc / pc_plus4, misalign_err, fetch_count)
// ---------------------------------------------------------------------------
module pc_next_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned INSTR_B  = 4,
    parameter int unsigned CNT_W    = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    pc_next_unit_if.master  bus
);

    localparam int unsigned PC_W     = 64;
    localparam int unsigned IMM26_W  = 26;
    localparam int unsigned IMM19_W  = 19;
    localparam int unsigned SEXT26_W = PC_W - IMM26_W - 2;
    localparam int unsigned SEXT19_W = PC_W - IMM19_W - 2;

    // A misaligned reset vector would make every sequential fetch misaligned.
    localparam logic [PC_W-1:0] RESET_PC_AL = {RESET_PC[PC_W-1:2], 2'b00};

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    state_e           state_q,        state_d;
    logic [PC_W-1:0]  pc_q,           pc_d;
    logic             fetch_valid_q,  fetch_valid_d;
    logic             misalign_err_q, misalign_err_d;
    logic [CNT_W-1:0] fetch_count_q,  fetch_count_d;

    logic             accept_c;
    logic             cond_taken_c;
    logic [PC_W-1:0]  seq_target_c;
    logic [PC_W-1:0]  b_target_c;
    logic [PC_W-1:0]  cb_target_c;
    logic [PC_W-1:0]  br_target_c;
    logic [PC_W-1:0]  b_offset_c;
    logic [PC_W-1:0]  cb_offset_c;

    // Candidate targets; every add wraps silently modulo 2^64.
    always_comb begin
        b_offset_c   = {{SEXT26_W{bus.imm26[IMM26_W-1]}}, bus.imm26, 2'b00};
        cb_offset_c  = {{SEXT19_W{bus.imm19[IMM19_W-1]}}, bus.imm19, 2'b00};
        seq_target_c = pc_q + PC_W'(INSTR_B);
        b_target_c   = pc_q + b_offset_c;
        cb_target_c  = pc_q + cb_offset_c;
        br_target_c  = {bus.reg_target[PC_W-1:2], 2'b00};
        cond_taken_c = bus.cond_br & bus.cond_true;
    end

    // fetch_valid_q is high only in RUN, so an accept implies RUN.
    assign accept_c = fetch_valid_q & bus.fetch_ready;

    // Next-state, next-PC and status computation.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        fetch_count_d  = fetch_count_q;
        misalign_err_d = 1'b0;

        unique case (state_q)
            ST_BOOT:   state_d = ST_RUN;
            ST_RUN:    if (bus.halt) state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_BOOT;
        endcase

        // A halt coinciding with an accept still lets that fetch complete.
        if (accept_c) begin
            fetch_count_d = fetch_count_q + CNT_W'(1);
            if (bus.br_reg) begin
                pc_d           = br_target_c;
                misalign_err_d = |bus.reg_target[1:0];
            end else if (bus.uncond_br) begin
                pc_d = b_target_c;
            end else if (cond_taken_c) begin
                pc_d = cb_target_c;
            end else begin
                pc_d = seq_target_c;
            end
        end

        fetch_valid_d = (state_d == ST_RUN);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_BOOT;
            pc_q           <= RESET_PC_AL;
            fetch_valid_q  <= 1'b0;
            misalign_err_q <= 1'b0;
            fetch_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            fetch_valid_q  <= fetch_valid_d;
            misalign_err_q <= misalign_err_d;
            fetch_count_q  <= fetch_count_d;
        end
    end

    assign bus.fetch_valid  = fetch_valid_q;
    assign bus.pc           = pc_q;
    assign bus.pc_plus4     = seq_target_c;
    assign bus.misalign_err = misalign_err_q;
    assign bus.fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_next_unit
// Purpose : directed self-checking bench for pc_next_unit.
// ---------------------------------------------------------------------------
module tb_pc_next_unit;

    logic clk;
    logic reset_n;

    int checks;
    int failures;
    logic [31:0] exp_cnt;

    pc_next_unit_if #(.CNT_W(32)) bus ();

    pc_next_unit #(
        .RESET_PC (64'h0),
        .INSTR_B  (4),
        .CNT_W    (32)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.fetch_ready = 1'b1;
        bus.uncond_br   = 1'b0;
        bus.cond_br     = 1'b0;
        bus.cond_true   = 1'b0;
        bus.br_reg      = 1'b0;
        bus.imm26       = '0;
        bus.imm19       = '0;
        bus.reg_target  = '0;
        bus.halt        = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        repeat (3) tick();
        checks++; if (bus.pc !== 64'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", bus.pc, 64'h0); end
        checks++; if (bus.fetch_valid !== 1'b0) begin failures++; $display("FAIL reset_fv got=%b exp=0", bus.fetch_valid); end
        checks++; if (bus.fetch_count !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", bus.fetch_count); end
        checks++; if (bus.misalign_err !== 1'b0) begin failures++; $display("FAIL reset_mis got=%b exp=0", bus.misalign_err); end
        checks++; if (bus.pc_plus4 !== 64'h4) begin failures++; $display("FAIL reset_plus4 got=%h exp=%h", bus.pc_plus4, 64'h4); end
        reset_n = 1'b1;
        exp_cnt = 0;
        checks++; if (bus.fetch_valid !== 1'b0) begin failures++; $display("FAIL boot_fv got=%b exp=0", bus.fetch_valid); end
        tick();
        checks++; if (bus.fetch_valid !== 1'b1) begin failures++; $display("FAIL run_fv got=%b exp=1", bus.fetch_valid); end
        checks++; if (bus.pc !== 64'h0) begin failures++; $display("FAIL run_pc0 got=%h exp=0", bus.pc); end
    endtask

    task automatic test_sequential();
        logic [63:0] exp_pc [3];
        exp_pc[0] = 64'h4; exp_pc[1] = 64'h8; exp_pc[2] = 64'hC;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_cnt++;
            checks++; if (bus.pc !== exp_pc[i]) begin failures++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, bus.pc, exp_pc[i]); end
        end
        checks++; if (bus.fetch_count !== 32'd3) begin failures++; $display("FAIL seq_cnt got=%0d exp=3", bus.fetch_count); end
    endtask

    task automatic test_branches();
        bus.br_reg = 1'b1; bus.reg_target = 64'h100;
        tick(); exp_cnt++;
        bus.br_reg = 1'b0;
        checks++; if (bus.pc !== 64'h100) begin failures++; $display("FAIL br_to_100 got=%h exp=%h", bus.pc, 64'h100); end
        checks++; if (bus.misalign_err !== 1'b0) begin failures++; $display("FAIL br_aligned_mis got=%b exp=0", bus.misalign_err); end
        bus.uncond_br = 1'b1; bus.imm26 = 26'h3FFFFFC;
        tick(); exp_cnt++;
        bus.uncond_br = 1'b0;
        checks++; if (bus.pc !== 64'hF0) begin failures++; $display("FAIL b_neg got=%h exp=%h", bus.pc, 64'hF0); end
        bus.cond_br = 1'b1; bus.cond_true = 1'b0; bus.imm19 = 19'd8;
        tick(); exp_cnt++;
        checks++; if (bus.pc !== 64'hF4) begin failures++; $display("FAIL cb_not_taken got=%h exp=%h", bus.pc, 64'hF4); end
        bus.cond_true = 1'b1;
        tick(); exp_cnt++;
        checks++; if (bus.pc !== 64'h114) begin failures++; $display("FAIL cb_taken got=%h exp=%h", bus.pc, 64'h114); end
        bus.imm19 = 19'h7FFFF;
        tick(); exp_cnt++;
        checks++; if (bus.pc !== 64'h110) begin failures++; $display("FAIL cb_neg got=%h exp=%h", bus.pc, 64'h110); end
        bus.uncond_br = 1'b1; bus.imm26 = 26'd1;
        tick(); exp_cnt++;
        checks++; if (bus.pc !== 64'h114) begin failures++; $display("FAIL b_over_cb got=%h exp=%h", bus.pc, 64'h114); end
        idle_inputs();
        checks++; if (bus.fetch_count !== exp_cnt) begin failures++; $display("FAIL br_cnt got=%0d exp=%0d", bus.fetch_count, exp_cnt); end
    endtask

    task automatic test_stall();
        bus.br_reg = 1'b1; bus.reg_target = 64'h40;
        tick(); exp_cnt++;
        bus.br_reg = 1'b0;
        bus.fetch_ready = 1'b0; bus.uncond_br = 1'b1; bus.imm26 = 26'd5;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus.pc !== 64'h40) begin failures++; $display("FAIL stall_pc[%0d] got=%h exp=%h", i, bus.pc, 64'h40); end
            checks++; if (bus.fetch_count !== exp_cnt) begin failures++; $display("FAIL stall_cnt[%0d] got=%0d exp=%0d", i, bus.fetch_count, exp_cnt); end
        end
        bus.fetch_ready = 1'b1;
        tick(); exp_cnt++;
        checks++; if (bus.pc !== 64'h54) begin failures++; $display("FAIL stall_release got=%h exp=%h", bus.pc, 64'h54); end
        checks++; if (bus.fetch_count !== exp_cnt) begin failures++; $display("FAIL stall_release_cnt got=%0d exp=%0d", bus.fetch_count, exp_cnt); end
        idle_inputs();
    endtask

    task automatic test_misalign();
        bus.br_reg = 1'b1; bus.uncond_br = 1'b1; bus.imm26 = 26'd100; bus.reg_target = 64'h2003;
        tick(); exp_cnt++;
        idle_inputs();
        checks++; if (bus.pc !== 64'h2000) begin failures++; $display("FAIL br_prio_pc got=%h exp=%h", bus.pc, 64'h2000); end
        checks++; if (bus.misalign_err !== 1'b1) begin failures++; $display("FAIL mis_pulse got=%b exp=1", bus.misalign_err); end
        tick(); exp_cnt++;
        checks++; if (bus.misalign_err !== 1'b0) begin failures++; $display("FAIL mis_clear got=%b exp=0", bus.misalign_err); end
        checks++; if (bus.pc !== 64'h2004) begin failures++; $display("FAIL mis_next_pc got=%h exp=%h", bus.pc, 64'h2004); end
        bus.fetch_ready = 1'b0; bus.br_reg = 1'b1; bus.reg_target = 64'h3001;
        tick();
        checks++; if (bus.misalign_err !== 1'b0) begin failures++; $display("FAIL mis_stalled got=%b exp=0", bus.misalign_err); end
        checks++; if (bus.pc !== 64'h2004) begin failures++; $display("FAIL mis_stalled_pc got=%h exp=%h", bus.pc, 64'h2004); end
        idle_inputs();
    endtask

    task automatic test_wrap_halt();
        bus.br_reg = 1'b1; bus.reg_target = 64'hFFFF_FFFF_FFFF_FFFC;
        tick(); exp_cnt++;
        bus.br_reg = 1'b0;
        checks++; if (bus.pc_plus4 !== 64'h0) begin failures++; $display("FAIL wrap_plus4 got=%h exp=0", bus.pc_plus4); end
        tick(); exp_cnt++;
        checks++; if (bus.pc !== 64'h0) begin failures++; $display("FAIL wrap_pc got=%h exp=0", bus.pc); end
        bus.halt = 1'b1;
        tick(); exp_cnt++;
        bus.halt = 1'b0;
        checks++; if (bus.pc !== 64'h4) begin failures++; $display("FAIL halt_adv got=%h exp=%h", bus.pc, 64'h4); end
        checks++; if (bus.fetch_valid !== 1'b0) begin failures++; $display("FAIL halt_fv got=%b exp=0", bus.fetch_valid); end
        checks++; if (bus.fetch_count !== exp_cnt) begin failures++; $display("FAIL halt_cnt got=%0d exp=%0d", bus.fetch_count, exp_cnt); end
        bus.uncond_br = 1'b1; bus.imm26 = 26'd3;
        repeat (3) tick();
        checks++; if (bus.pc !== 64'h4) begin failures++; $display("FAIL halted_pc got=%h exp=%h", bus.pc, 64'h4); end
        checks++; if (bus.fetch_valid !== 1'b0) begin failures++; $display("FAIL halted_fv got=%b exp=0", bus.fetch_valid); end
        checks++; if (bus.fetch_count !== exp_cnt) begin failures++; $display("FAIL halted_cnt got=%0d exp=%0d", bus.fetch_count, exp_cnt); end
        checks++; if (bus.pc_plus4 !== 64'h8) begin failures++; $display("FAIL halted_plus4 got=%h exp=%h", bus.pc_plus4, 64'h8); end
        idle_inputs();
    endtask

    task automatic test_boot_halt_and_reset();
        // Async reset from HALTED, between clock edges.
        bus.halt = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        checks++; if (bus.pc !== 64'h0) begin failures++; $display("FAIL rst_halt_pc got=%h exp=0", bus.pc); end
        checks++; if (bus.fetch_count !== 32'd0) begin failures++; $display("FAIL rst_halt_cnt got=%0d exp=0", bus.fetch_count); end
        tick();
        reset_n = 1'b1;
        checks++; if (bus.fetch_valid !== 1'b0) begin failures++; $display("FAIL reboot_fv got=%b exp=0", bus.fetch_valid); end
        tick();
        checks++; if (bus.fetch_valid !== 1'b1) begin failures++; $display("FAIL boot_halt_ignored got=%b exp=1", bus.fetch_valid); end
        bus.halt = 1'b0;
        tick();
        checks++; if (bus.pc !== 64'h4) begin failures++; $display("FAIL reboot_pc got=%h exp=%h", bus.pc, 64'h4); end
        checks++; if (bus.fetch_valid !== 1'b1) begin failures++; $display("FAIL reboot_run got=%b exp=1", bus.fetch_valid); end
        tick();
        bus.fetch_ready = 1'b0;
        repeat (2) tick();
        checks++; if (bus.pc !== 64'h8) begin failures++; $display("FAIL pre_rst_stall_pc got=%h exp=%h", bus.pc, 64'h8); end
        #3 reset_n = 1'b0;
        #1;
        checks++; if (bus.pc !== 64'h0) begin failures++; $display("FAIL rst_stall_pc got=%h exp=0", bus.pc); end
        checks++; if (bus.fetch_valid !== 1'b0) begin failures++; $display("FAIL rst_stall_fv got=%b exp=0", bus.fetch_valid); end
        checks++; if (bus.fetch_count !== 32'd0) begin failures++; $display("FAIL rst_stall_cnt got=%0d exp=0", bus.fetch_count); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_cnt  = 0;
        reset_n  = 1'b0;
        idle_inputs();
        test_reset();
        test_sequential();
        test_branches();
        test_stall();
        test_misalign();
        test_wrap_halt();
        test_boot_halt_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
